// File: rtl/uart_result_tx_pkg.sv
// Shared constants and character helpers for the ALU result UART transmitter.
// Holds the serializer state encodings, the ASCII codes and the frame character map.
package uart_result_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int unsigned NUM_CHARS     = 4;
    localparam int unsigned BITS_PER_CHAR = 8;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
        if (n < 4'd10) begin
            return ASCII_0 + 8'(n);
        end
        return ASCII_A + 8'(n - 4'd10);
    endfunction

    // Character idx of the frame: hex-hi, hex-lo, CR, LF.
    function automatic logic [7:0] frame_char(input logic [7:0] r, input logic [1:0] idx);
        case (idx)
            2'd0:    return nibble_to_hex(r[7:4]);
            2'd1:    return nibble_to_hex(r[3:0]);
            2'd2:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

endpackage

// File: rtl/uart_result_tx_if.sv
// Pin-level bundle between the ALU top level and the result transmitter.
interface uart_result_tx_if;
    logic [7:0] result;
    logic       uart_tx_en;
    logic       uartbusy;
    logic       uart_txd;

    modport master (output result, output uart_tx_en, input uartbusy, input uart_txd);
    modport slave  (input result, input uart_tx_en, output uartbusy, output uart_txd);
endinterface

// File: rtl/uart_result_tx_byte.sv
// 8N1 serializer, LSB first. byte_ready_c is also high in the last STOP cycle so
// a byte presented then follows the stop bit with no idle gap.
module uart_result_tx_byte
    import uart_result_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1042
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid_c,
    input  logic [7:0] byte_data_c,
    output logic       byte_ready_c,
    output logic       txd
);

    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      BIT_LAST = 3'(BITS_PER_CHAR - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             bit_end_c;

    assign bit_end_c    = (cnt_q == CNT_LAST);
    assign byte_ready_c = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end_c);
    assign txd          = txd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_START: begin
                if (bit_end_c) begin
                    state_d = ST_DATA;
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: ;
        endcase

        // Accepting a byte overrides the end-of-STOP return to idle.
        if (byte_ready_c && byte_valid_c) begin
            state_d = ST_START;
            shift_d = byte_data_c;
            txd_d   = 1'b0;
            cnt_d   = '0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: rtl/uart_result_tx.sv
// Sends the ALU result as "HL\r\n" over UART on each rising edge of uart_tx_en.
// Adds the input synchronizer, edge detect, result latch and character sequencer.
module uart_result_tx
    import uart_result_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1042
) (
    input  logic             clk,
    input  logic             reset,
    uart_result_tx_if.slave  bus
);

    localparam logic [1:0] CHAR_LAST = 2'(NUM_CHARS - 1);

    logic       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic       busy_q, busy_d;
    logic [1:0] char_idx_q, char_idx_d;
    logic [7:0] result_q, result_d;
    logic       start_c;
    logic       byte_valid_c;
    logic [7:0] byte_data_c;
    logic       byte_ready_c;
    logic       txd;

    assign start_c      = s2_q & ~s3_q;
    assign bus.uartbusy = busy_q;
    assign bus.uart_txd = txd;

    // Sequencer: first character straight from the live result at acceptance,
    // later ones from the latched copy as the serializer finishes each stop bit.
    always_comb begin
        s1_d         = bus.uart_tx_en;
        s2_d         = s1_q;
        s3_d         = s2_q;
        busy_d       = busy_q;
        char_idx_d   = char_idx_q;
        result_d     = result_q;
        byte_valid_c = 1'b0;
        byte_data_c  = frame_char(result_q, char_idx_q + 2'd1);

        if (!busy_q) begin
            if (start_c) begin
                byte_valid_c = 1'b1;
                byte_data_c  = frame_char(bus.result, 2'd0);
                if (byte_ready_c) begin
                    busy_d     = 1'b1;
                    result_d   = bus.result;
                    char_idx_d = '0;
                end
            end
        end else if (byte_ready_c) begin
            if (char_idx_q != CHAR_LAST) begin
                byte_valid_c = 1'b1;
                char_idx_d   = char_idx_q + 2'd1;
            end else begin
                busy_d     = 1'b0;
                char_idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            busy_q     <= 1'b0;
            char_idx_q <= '0;
            result_q   <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            busy_q     <= busy_d;
            char_idx_q <= char_idx_d;
            result_q   <= result_d;
        end
    end

    uart_result_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk          (clk),
        .reset        (reset),
        .byte_valid_c (byte_valid_c),
        .byte_data_c  (byte_data_c),
        .byte_ready_c (byte_ready_c),
        .txd          (txd)
    );

endmodule
